div_32_seq: RTL and testbench
=============================

// Module: div_32_seq
// PURPOSE
//   Multi-cycle signed integer divider for the ALU DIV instruction; complements the
//   single-cycle CSA multiplier path. Iterative shift/subtract (non-restoring) over
//   WIDTH cycles with a start/done handshake. LO <= quotient, HI <= remainder.
//   Sits beside the multiplier in the ALU; the control unit stalls on busy.
// PARAMETERS
//   WIDTH  32  operand/quotient/remainder width; iteration count; >= 2
// PORTS
//   clk          in   1      rising-edge clock
//   clr          in   1      asynchronous active-low reset
//   start        in   1      request; sampled only in IDLE
//   dividend     in   WIDTH  signed dividend, captured on accepted start
//   divisor      in   WIDTH  signed divisor, captured on accepted start
//   busy         out  1      high in RUN and FIX
//   done         out  1      one-cycle pulse; quotient/remainder valid from this cycle
//   quotient     out  WIDTH  signed quotient, truncated toward zero
//   remainder    out  WIDTH  signed remainder, sign follows dividend
//   div_by_zero  out  1      set with done when divisor == 0; held with results
// BEHAVIOUR
//   Reset (clr=0, any state, async): state=IDLE; busy, done, div_by_zero = 0;
//     quotient, remainder = 0; counter and working registers = 0. No partial result.
//   States: IDLE, RUN, FIX, DONE.
//   IDLE: start=1 at edge k -> capture operands, magnitudes |a|,|b|, q_neg=a[MSB]^b[MSB],
//     r_neg=a[MSB]; counter=0; -> RUN. If divisor==0 -> DONE directly.
//   RUN: one quotient bit per cycle; partial remainder WIDTH+1 bits (extra sign bit);
//     add or subtract |b| by partial-remainder sign. After WIDTH iterations
//     (edge k+WIDTH) -> FIX.
//   FIX: negative partial remainder gets one |b| restore; apply signs (two's-complement
//     negate quotient if q_neg, remainder if r_neg); register outputs -> DONE.
//   DONE: done=1 for exactly one cycle -> IDLE. Start is ignored in DONE.
//   Latency: start at edge k -> done high after edge k+WIDTH+1 (33 for WIDTH=32);
//     busy high after edges k..k+WIDTH; low when done rises.
//   Divide by zero: done after edge k+1; quotient={WIDTH{1'b1}}, remainder=dividend,
//     div_by_zero=1; busy never asserts.
//   Overflow: -2^(WIDTH-1) / -1 -> quotient=2^(WIDTH-1) as raw bits (0x80000000), remainder=0,
//     no flag. Magnitude of -2^(WIDTH-1) is treated as unsigned WIDTH-bit.
//   Start while busy or in DONE: ignored; operands not re-captured; result unaffected.
//   Outputs: hold last result until the next accepted start's done. div_by_zero clears
//     on the next accepted start.
//   Operand inputs may change after the accepted start without effect.
// TESTING
//   100 / 7, start at edge 0 -> done after edge 33, quotient=14, remainder=2, busy 0..32.
//   -100 / 7 -> quotient=-14 (0xFFFFFFF2), remainder=-2; 100 / -7 -> -14, 2;
//     -100 / -7 -> 14, -2.
//   0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
//   1234 / 0 -> done after edge 1, quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1.
//   Start pulses at edges 5 and 20 of a run started at 0 with new operands ->
//     single done at edge 33, result from first operands.
//   clr low at edge 10 of a run -> all outputs 0 immediately; start at 12 -> done at 45.
//   Random signed pairs (incl. 0, +/-1, extremes) vs reference model: q*b+r==a,
//     |r|<|b|, sign(r)=sign(a) or r==0.

Source files
------------

// File: rtl/div_32_seq.sv
// Multi-cycle signed integer divider for the ALU DIV instruction.
// Non-restoring shift/subtract over WIDTH iterations, start/done handshake.
// The quotient is truncated toward zero. The remainder takes the sign of the dividend.
module div_32_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   part_q;     // partial remainder with extra sign bit
    logic [WIDTH-1:0] work_q;     // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic             q_neg_q;
    logic             r_neg_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;
    logic [WIDTH:0]   shift_d;
    logic [WIDTH:0]   part_d;
    logic [WIDTH:0]   rfix_d;
    logic [WIDTH-1:0] q_res_d;
    logic [WIDTH-1:0] r_res_d;

    // Operand magnitudes. The most negative value maps to 2^(WIDTH-1) as an unsigned number.
    always_comb begin
        a_mag_d = dividend[WIDTH-1] ? -dividend : dividend;
        b_mag_d = divisor[WIDTH-1]  ? -divisor  : divisor;
    end

    // One non-restoring step. Add the divisor when the partial remainder is negative,
    // otherwise subtract it.
    always_comb begin
        shift_d = {part_q[WIDTH-1:0], work_q[WIDTH-1]};
        if (part_q[WIDTH]) begin
            part_d = shift_d + {1'b0, dvs_q};
        end else begin
            part_d = shift_d - {1'b0, dvs_q};
        end
    end

    // Final correction: restore a negative remainder once, then apply the signs.
    always_comb begin
        rfix_d  = part_q[WIDTH] ? (part_q + {1'b0, dvs_q}) : part_q;
        q_res_d = q_neg_q ? -work_q : work_q;
        r_res_d = r_neg_q ? -rfix_d[WIDTH-1:0] : rfix_d[WIDTH-1:0];
    end

    // Control FSM with the working datapath and registered outputs.
    // A divide by zero enters DONE with done low. It then spends one extra DONE cycle
    // publishing the result, which gives it a two-edge latency without ever raising busy.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            part_q      <= '0;
            work_q      <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dbz_q   <= 1'b0;
                        cnt_q   <= '0;
                        part_q  <= '0;
                        q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg_q <= dividend[WIDTH-1];
                        if (divisor == '0) begin
                            work_q  <= dividend;
                            dvs_q   <= '0;
                            state_q <= S_DONE;
                        end else begin
                            work_q  <= a_mag_d;
                            dvs_q   <= b_mag_d;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    part_q <= part_d;
                    work_q <= {work_q[WIDTH-2:0], ~part_d[WIDTH]};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    quotient_q  <= q_res_d;
                    remainder_q <= r_res_d;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (!done_q) begin
                        quotient_q  <= '1;
                        remainder_q <= work_q;
                        dbz_q       <= 1'b1;
                        done_q      <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_32_seq.sv
// Self-checking bench for div_32_seq. It compares against a plain-arithmetic signed division model.
module tb_div_32_seq;

    localparam int unsigned W = 32;

    logic         clk;
    logic         clr;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;

    div_32_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit signed division, truncated back to W bits.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
        end
    endfunction

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke,
                           input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic [W-1:0] rel;
        longint       mr;
        longint       mb;
        bit           busy_ok;
        bit           rel_ok;
        int           j;
        int           exp_lat;
        ref_div(a, b, eq, er);
        exp_lat = (b == '0) ? 1 : W + 1;

        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;

        check({tag, "_dbz_clr"}, div_by_zero, 0);
        check({tag, "_hold"}, {quotient, remainder}, {prev_q, prev_r});

        j = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && j < 100) begin
            if (busy !== ((b != '0) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
            if (poke && (j == 4 || j == 19)) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = $urandom;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            j++;
        end

        check({tag, "_latency"}, j, exp_lat);
        check({tag, "_busy_run"}, busy_ok, 1);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_quot"}, quotient, eq);
        check({tag, "_rem"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, (b == '0) ? 1 : 0);

        if (b != '0) begin
            rel = quotient * b + remainder;
            mr  = $signed(remainder);
            mb  = $signed(b);
            if (mr < 0) mr = -mr;
            if (mb < 0) mb = -mb;
            rel_ok = (rel == a) && (mr < mb) &&
                     (remainder == '0 || remainder[W-1] == a[W-1]);
            check({tag, "_relation"}, rel_ok, 1);
        end
        prev_q = eq;
        prev_r = er;

        // A start raised during the DONE cycle must be ignored.
        start    = poke;
        dividend = $urandom;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        if (poke) begin
            @(posedge clk);
            #1;
            check({tag, "_start_in_done"}, busy, 0);
            check({tag, "_result_kept"}, quotient, eq);
        end
    endtask

    logic [W-1:0] specials [8];
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    initial begin
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        specials[5] = 32'h8000_0001;
        specials[6] = 32'h0000_0002;
        specials[7] = 32'hFFFF_FFFE;

        clr      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        prev_q   = '0;
        prev_r   = '0;
        #1;
        check("reset_quot", quotient, 0);
        check("reset_rem", remainder, 0);
        check("reset_flags", {busy, done, div_by_zero}, 0);
        repeat (2) @(negedge clk);
        clr = 1'b1;

        run_div(32'd100, 32'd7, 1'b0, "p_by_p");
        run_div(-32'sd100, 32'd7, 1'b0, "n_by_p");
        run_div(32'd100, -32'sd7, 1'b0, "p_by_n");
        run_div(-32'sd100, -32'sd7, 1'b0, "n_by_n");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "overflow");
        run_div(32'd1234, 32'd0, 1'b0, "div_zero");
        run_div(32'd100, 32'd7, 1'b1, "start_busy");

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        check("midrst_quot", quotient, 0);
        check("midrst_rem", remainder, 0);
        check("midrst_flags", {busy, done, div_by_zero}, 0);
        @(negedge clk);
        clr    = 1'b1;
        prev_q = '0;
        prev_r = '0;
        run_div(32'd100, 32'd7, 1'b0, "after_rst");

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
            rb = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_div(ra, rb, 1'b0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
